// File: rtl/reg_arb_pkg.sv
// Shared types and the round-robin pick helper for reg_native bus sharers.
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    localparam int RR_MAX = 8;

    // First set bit of req_mask at or after ptr, wrapping modulo n (n <= RR_MAX).
    function automatic int rr_pick(input logic [RR_MAX-1:0] req_mask, input int ptr, input int n);
        int   win;
        int   idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = (ptr + k) % n;
            if (!found && (k < n) && req_mask[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/reg_native_rr_arbiter.sv
// Round-robin winner select with a pointer that moves past the last served requester.
module reg_native_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    input  logic [IW-1:0] adv_idx_i,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (adv_idx_i == IW'(N - 1)) ? '0 : adv_idx_i + IW'(1);
        end
    end

    assign gnt_idx_o = IW'(rr_pick(RR_MAX'(req_i), int'(ptr_q), N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_native_arbiter.sv
// Shares one downstream reg_native port between MST_NUM masters: per-master
// pending slot, round-robin grant, one outstanding transaction, ack timeout.
module reg_native_arbiter
    import reg_arb_pkg::*;
#(
    parameter int MST_NUM        = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [MST_NUM-1:0]                   upstream__req_vld,
    output logic [MST_NUM-1:0]                   upstream__ack_vld,
    input  logic [MST_NUM-1:0][ADDR_WIDTH-1:0]   upstream__addr,
    input  logic [MST_NUM-1:0]                   upstream__wr_en,
    input  logic [MST_NUM-1:0]                   upstream__rd_en,
    input  logic [MST_NUM-1:0][DATA_WIDTH-1:0]   upstream__wr_data,
    output logic [MST_NUM-1:0][DATA_WIDTH-1:0]   upstream__rd_data,
    output logic                                 downstream__req_vld,
    input  logic                                 downstream__ack_vld,
    output logic [ADDR_WIDTH-1:0]                downstream__addr,
    output logic                                 downstream__wr_en,
    output logic                                 downstream__rd_en,
    output logic [DATA_WIDTH-1:0]                downstream__wr_data,
    input  logic [DATA_WIDTH-1:0]                downstream__rd_data,
    output logic                                 timeout_err,
    output logic                                 proto_err
);

    localparam int IW = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wr_en;
        logic                  rd_en;
        logic [DATA_WIDTH-1:0] wr_data;
    } reg_req_t;

    arb_state_e                  state_q, state_d;
    logic [MST_NUM-1:0]          occ_q, occ_d;
    reg_req_t [MST_NUM-1:0]      slot_q, slot_d;
    reg_req_t                    hold_q, hold_d;
    logic [IW-1:0]               win_q, win_d;
    logic [IW-1:0]               gnt_idx;
    logic [31:0]                 cnt_q, cnt_d;
    logic [MST_NUM-1:0]          ack_q, ack_d;
    logic [DATA_WIDTH-1:0]       rd_q, rd_d;
    logic                        tmo_q, tmo_d;
    logic                        perr_q, perr_d;
    logic                        grant, tmo_hit, done;
    reg_req_t                    ds_sel;

    reg_native_rr_arbiter #(.N(MST_NUM), .IW(IW)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (occ_q),
        .adv_i     (done),
        .adv_idx_i (win_q),
        .gnt_idx_o (gnt_idx)
    );

    // Grant is held off during the upstream ack cycle, giving 3 cycles per transaction.
    assign grant   = (state_q == IDLE) && (|occ_q) && !(|ack_q);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && !downstream__ack_vld &&
                     (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign done    = (state_q == WAIT) && (downstream__ack_vld || tmo_hit);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        rd_d    = '0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    win_d   = gnt_idx;
                    hold_d  = slot_q[gnt_idx];
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (downstream__ack_vld) begin
                    ack_d[win_q] = 1'b1;
                    rd_d         = downstream__rd_data;
                    state_d      = IDLE;
                end else if (tmo_hit) begin
                    ack_d[win_q] = 1'b1;
                    rd_d         = ERR_DATA;
                    tmo_d        = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Freeing a slot wins over a same-edge capture; any request into an occupied slot is a violation.
    always_comb begin
        occ_d  = occ_q;
        slot_d = slot_q;
        perr_d = perr_q;
        for (int i = 0; i < MST_NUM; i++) begin
            if (done && (win_q == IW'(i))) begin
                occ_d[i] = 1'b0;
            end else if (upstream__req_vld[i] && !occ_q[i]) begin
                occ_d[i]          = 1'b1;
                slot_d[i].addr    = upstream__addr[i];
                slot_d[i].wr_en   = upstream__wr_en[i];
                slot_d[i].rd_en   = upstream__rd_en[i];
                slot_d[i].wr_data = upstream__wr_data[i];
            end
            if (upstream__req_vld[i] && occ_q[i]) begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            occ_q   <= '0;
            slot_q  <= '0;
            hold_q  <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            slot_q  <= slot_d;
            hold_q  <= hold_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            perr_q  <= perr_d;
        end
    end

    assign ds_sel              = grant ? slot_q[gnt_idx] : hold_q;
    assign downstream__req_vld = grant;
    assign downstream__addr    = ds_sel.addr;
    assign downstream__wr_en   = ds_sel.wr_en;
    assign downstream__rd_en   = ds_sel.rd_en;
    assign downstream__wr_data = ds_sel.wr_data;

    assign upstream__ack_vld = ack_q;
    for (genvar g = 0; g < MST_NUM; g++) begin : g_rsp
        assign upstream__rd_data[g] = ack_q[g] ? rd_q : '0;
    end

    assign timeout_err = tmo_q;
    assign proto_err   = perr_q;

endmodule
